// File: rtl/renode_axi_pkg.sv
// Shared AXI types for the standalone burst RAM subordinate.
// Holds the burst/response encodings, the latched request record and a
// helper that ranks response codes so a burst can report its worst beat.
package renode_axi_pkg;

    // Internal request fields are sized for the widest bus the RAM supports.
    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_ID_W   = 4;
    localparam int unsigned AXI_LEN_W  = 8;
    localparam int unsigned AXI_SIZE_W = 3;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    // Latched request: id, address of the beat to service next, len, size.
    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic [AXI_SIZE_W-1:0] size;
    } axi_beat_t;

    // Encodings are ordered by severity, so the larger code wins.
    function automatic resp_e resp_worst(input resp_e a, input resp_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/renode_axi_burst_addr.sv
// Combinational beat address helper for one AXI channel.
// Ports:
//   addr        - address of the current beat
//   size/burst  - beat size (log2 bytes) and burst type of the transaction
//   next_addr_c - address of the following beat
//   in_range_c  - current beat falls inside the memory array
//   legal_c     - burst type and size are supported (FIXED/INCR, size <= bus width)
module renode_axi_burst_addr
    import renode_axi_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned MemBytes  = 4096
) (
    input  logic [AXI_ADDR_W-1:0] addr,
    input  logic [AXI_SIZE_W-1:0] size,
    input  burst_e                burst,
    output logic [AXI_ADDR_W-1:0] next_addr_c,
    output logic                  in_range_c,
    output logic                  legal_c
);

    localparam int unsigned LANE_AW = $clog2(DataWidth / 8);

    // WRAP and the reserved encoding are rejected; the address is left alone for them.
    always_comb begin
        legal_c     = ((burst == BURST_FIXED) || (burst == BURST_INCR)) &&
                      (size <= AXI_SIZE_W'(LANE_AW));
        in_range_c  = (addr < AXI_ADDR_W'(MemBytes));
        next_addr_c = addr;
        if (burst == BURST_INCR) begin
            next_addr_c = addr + (AXI_ADDR_W'(1) << size);
        end
    end

endmodule

// File: rtl/renode_axi_burst_ram.sv
// AXI4 subordinate memory model answering the DMA data-side manager so DMA
// bursts complete in pure RTL. Independent read and write FSMs share one
// byte-addressable array; one outstanding transaction per direction.
// Ports:
//   clk, areset_n                       - clock, async active-low reset
//   aw*/awvalid/awready                 - write address channel
//   wdata/wstrb/wlast/wvalid/wready     - write data channel
//   bid/bresp/bvalid/bready             - write response channel
//   ar*/arvalid/arready                 - read address channel
//   rid/rdata/rresp/rlast/rvalid/rready - read data channel
module renode_axi_burst_ram
    import renode_axi_pkg::*;
#(
    parameter int unsigned AddrWidth = AXI_ADDR_W,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = AXI_ID_W,
    parameter int unsigned MemBytes  = 4096
) (
    input  logic                   clk,
    input  logic                   areset_n,

    input  logic [IdWidth-1:0]     awid,
    input  logic [AddrWidth-1:0]   awaddr,
    input  logic [7:0]             awlen,
    input  logic [2:0]             awsize,
    input  logic [1:0]             awburst,
    input  logic                   awvalid,
    output logic                   awready,

    input  logic [DataWidth-1:0]   wdata,
    input  logic [DataWidth/8-1:0] wstrb,
    input  logic                   wlast,
    input  logic                   wvalid,
    output logic                   wready,

    output logic [IdWidth-1:0]     bid,
    output logic [1:0]             bresp,
    output logic                   bvalid,
    input  logic                   bready,

    input  logic [IdWidth-1:0]     arid,
    input  logic [AddrWidth-1:0]   araddr,
    input  logic [7:0]             arlen,
    input  logic [2:0]             arsize,
    input  logic [1:0]             arburst,
    input  logic                   arvalid,
    output logic                   arready,

    output logic [IdWidth-1:0]     rid,
    output logic [DataWidth-1:0]   rdata,
    output logic [1:0]             rresp,
    output logic                   rlast,
    output logic                   rvalid,
    input  logic                   rready
);

    localparam int unsigned LANES   = DataWidth / 8;
    localparam int unsigned LANE_AW = $clog2(LANES);
    localparam int unsigned MEM_AW  = $clog2(MemBytes);
    localparam int unsigned WORD_AW = MEM_AW - LANE_AW;

    typedef enum logic       {R_IDLE, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

    logic [7:0] mem [MemBytes];

    // ---------------- read channel state ----------------
    r_state_e              r_state, r_state_d;
    axi_beat_t             r_beat, r_beat_d;
    burst_e                r_burst, r_burst_d;
    logic [AXI_LEN_W-1:0]  r_cnt, r_cnt_d;
    resp_e                 r_resp, r_resp_d;
    logic                  arready_d, rvalid_d, rlast_d;
    logic [DataWidth-1:0]  rdata_d;
    logic                  r_load;

    logic [AXI_ADDR_W-1:0] ra_addr, ra_next;
    logic [AXI_SIZE_W-1:0] ra_size;
    burst_e                ra_burst;
    logic                  ra_in_range, ra_legal;
    logic [WORD_AW-1:0]    ra_idx;
    logic [DataWidth-1:0]  rd_word;

    // ---------------- write channel state ----------------
    w_state_e              w_state, w_state_d;
    axi_beat_t             w_beat, w_beat_d;
    burst_e                w_burst, w_burst_d;
    logic [AXI_LEN_W-1:0]  w_cnt, w_cnt_d;
    resp_e                 w_acc, w_acc_d;
    resp_e                 w_beat_resp;
    logic                  awready_d, wready_d, bvalid_d;
    logic                  mem_we;

    logic [AXI_ADDR_W-1:0] wa_next;
    logic                  wa_in_range, wa_legal;
    logic [WORD_AW-1:0]    wa_idx;

    assign rid   = IdWidth'(r_beat.id);
    assign rresp = 2'(r_resp);
    assign bid   = IdWidth'(w_beat.id);
    assign bresp = 2'(w_acc);

    // Beat 0 is taken straight from the AR bus; later beats from the latched request.
    always_comb begin
        ra_addr  = r_beat.addr;
        ra_size  = r_beat.size;
        ra_burst = r_burst;
        if (r_state == R_IDLE) begin
            ra_addr  = AXI_ADDR_W'(araddr);
            ra_size  = AXI_SIZE_W'(arsize);
            ra_burst = burst_e'(arburst);
        end
    end

    renode_axi_burst_addr #(
        .DataWidth (DataWidth),
        .MemBytes  (MemBytes)
    ) u_rd_addr (
        .addr        (ra_addr),
        .size        (ra_size),
        .burst       (ra_burst),
        .next_addr_c (ra_next),
        .in_range_c  (ra_in_range),
        .legal_c     (ra_legal)
    );

    renode_axi_burst_addr #(
        .DataWidth (DataWidth),
        .MemBytes  (MemBytes)
    ) u_wr_addr (
        .addr        (w_beat.addr),
        .size        (w_beat.size),
        .burst       (w_burst),
        .next_addr_c (wa_next),
        .in_range_c  (wa_in_range),
        .legal_c     (wa_legal)
    );

    assign ra_idx = ra_addr[MEM_AW-1:LANE_AW];
    assign wa_idx = w_beat.addr[MEM_AW-1:LANE_AW];

    // Read port: sees the array before any write committing on the same edge.
    always_comb begin
        rd_word = '0;
        for (int b = 0; b < int'(LANES); b++) begin
            rd_word[8*b +: 8] = mem[{ra_idx, LANE_AW'(b)}];
        end
    end

    // Single write port; narrow beats rely on the manager's strobes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(LANES); b++) begin
                if (wstrb[b]) begin
                    mem[{wa_idx, LANE_AW'(b)}] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read FSM next-state and registered-output values.
    always_comb begin
        r_state_d = r_state;
        r_beat_d  = r_beat;
        r_burst_d = r_burst;
        r_cnt_d   = r_cnt;
        r_resp_d  = r_resp;
        rvalid_d  = rvalid;
        rdata_d   = rdata;
        rlast_d   = rlast;
        r_load    = 1'b0;

        case (r_state)
            R_IDLE: begin
                if (arvalid && arready) begin
                    r_beat_d.id   = AXI_ID_W'(arid);
                    r_beat_d.len  = AXI_LEN_W'(arlen);
                    r_beat_d.size = AXI_SIZE_W'(arsize);
                    r_beat_d.addr = ra_next;
                    r_burst_d     = burst_e'(arburst);
                    r_cnt_d       = '0;
                    rlast_d       = (arlen == 8'd0);
                    r_load        = 1'b1;
                    r_state_d     = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid && rready) begin
                    if (rlast) begin
                        rvalid_d  = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d       = AXI_LEN_W'(r_cnt + 8'd1);
                        rlast_d       = (AXI_LEN_W'(r_cnt + 8'd1) == r_beat.len);
                        r_beat_d.addr = ra_next;
                        r_load        = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        // Illegal bursts report SLVERR on every beat, ahead of any decode error.
        if (r_load) begin
            rvalid_d = 1'b1;
            rdata_d  = (ra_legal && ra_in_range) ? rd_word : '0;
            if (!ra_legal) begin
                r_resp_d = RESP_SLVERR;
            end else if (!ra_in_range) begin
                r_resp_d = RESP_DECERR;
            end else begin
                r_resp_d = RESP_OKAY;
            end
        end

        arready_d = (r_state_d == R_IDLE);
    end

    // Read FSM registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= R_IDLE;
            r_beat  <= '0;
            r_burst <= BURST_FIXED;
            r_cnt   <= '0;
            r_resp  <= RESP_OKAY;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rlast   <= 1'b0;
        end else begin
            r_state <= r_state_d;
            r_beat  <= r_beat_d;
            r_burst <= r_burst_d;
            r_cnt   <= r_cnt_d;
            r_resp  <= r_resp_d;
            arready <= arready_d;
            rvalid  <= rvalid_d;
            rdata   <= rdata_d;
            rlast   <= rlast_d;
        end
    end

    // Write FSM next-state values; the burst ends on beat count, not on wlast.
    always_comb begin
        w_state_d   = w_state;
        w_beat_d    = w_beat;
        w_burst_d   = w_burst;
        w_cnt_d     = w_cnt;
        w_acc_d     = w_acc;
        w_beat_resp = RESP_OKAY;
        mem_we      = 1'b0;

        case (w_state)
            W_IDLE: begin
                if (awvalid && awready) begin
                    w_beat_d.id   = AXI_ID_W'(awid);
                    w_beat_d.addr = AXI_ADDR_W'(awaddr);
                    w_beat_d.len  = AXI_LEN_W'(awlen);
                    w_beat_d.size = AXI_SIZE_W'(awsize);
                    w_burst_d     = burst_e'(awburst);
                    w_cnt_d       = '0;
                    w_acc_d       = RESP_OKAY;
                    w_state_d     = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid && wready) begin
                    mem_we = wa_legal && wa_in_range;
                    if (!wa_legal) begin
                        w_beat_resp = RESP_SLVERR;
                    end else if (!wa_in_range) begin
                        w_beat_resp = RESP_DECERR;
                    end
                    // A misplaced wlast is flagged but the data still lands.
                    if (wlast != (w_cnt == w_beat.len)) begin
                        w_beat_resp = resp_worst(w_beat_resp, RESP_SLVERR);
                    end
                    w_acc_d = resp_worst(w_acc, w_beat_resp);
                    if (w_cnt == w_beat.len) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d       = AXI_LEN_W'(w_cnt + 8'd1);
                        w_beat_d.addr = wa_next;
                    end
                end
            end
            W_RESP: begin
                if (bvalid && bready) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase

        awready_d = (w_state_d == W_IDLE);
        wready_d  = (w_state_d == W_DATA);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Write FSM registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            w_state <= W_IDLE;
            w_beat  <= '0;
            w_burst <= BURST_FIXED;
            w_cnt   <= '0;
            w_acc   <= RESP_OKAY;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
        end else begin
            w_state <= w_state_d;
            w_beat  <= w_beat_d;
            w_burst <= w_burst_d;
            w_cnt   <= w_cnt_d;
            w_acc   <= w_acc_d;
            awready <= awready_d;
            wready  <= wready_d;
            bvalid  <= bvalid_d;
        end
    end

endmodule
